bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Shares the single read/write port of one 1024x8 coprocessor operand BRAM between three requesters:
- P0, the UART loader (writes);
- P1, the compute engine (reads);
- P2, the UART readback path (reads).

Ownership-based arbitration with a registered grant. P0 has fixed priority, and P1/P2 are served round-robin. Each read-data-valid strobe is routed back to the requester that issued the read. The block sits between the requester blocks and the BRAM instance in each operand-memory slice.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive owned cycles for P1/P2 while `req[0]` is pending.
- `AW`, default 10: address width.
- `DW`, default 8: data width.

Ports:
- `clk`, in, 1: single clock. One clock; reset is asynchronous and active-low.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req`, in, 3: per-requester ownership request, bit i is Pi.
- `acc_en`, in, 3: per-requester access strobe. Honoured only while granted.
- `acc_we`, in, 3: per-requester write enable.
- `acc_addr`, in, 3*AW: packed `{P2,P1,P0}` addresses.
- `acc_din`, in, 3*DW: packed `{P2,P1,P0}` write data.
- `gnt`, out, 3: one-hot ownership, or all zero.
- `rvalid`, out, 3: one-cycle read-return strobe to the issuing requester.
- `rdata`, out, DW: shared read data. It equals `bram_dout` and is meaningful only with `rvalid`.
- `bram_en`, out, 1: BRAM port enable.
- `bram_we`, out, 1: BRAM write enable.
- `bram_addr`, out, AW: BRAM address.
- `bram_din`, out, DW: BRAM write data.
- `bram_dout`, in, DW: BRAM registered read data (1-cycle latency).
- `owner`, out, 2: state code: 0=NONE, 1=P0, 2=P1, 3=P2.

## Operation
- **FSM states:** NONE, OWN0, OWN1, OWN2. These are registered, and `gnt` decodes directly from the state.
- **Next-owner selection (`pick`):**
  - P0 if `req[0]` is set.
  - Otherwise, if both `req[1]` and `req[2]` are set, the one not served last (`rr_last` flag, reset selects P1 first).
  - Otherwise the single requester that is requesting.
  - Otherwise NONE.
- **NONE:** next = `pick`.
- **OWNi:**
  - Remains while `req[i]` is high.
  - When `req[i]` drops, next = `pick`, evaluated with `req[i]` excluded. Handover takes no idle cycle.
- **Preemption:**
  - In OWN1/OWN2, `hold_cnt` counts owned cycles while `req[0]` is high. It is cleared on every state change and whenever `req[0]` is low.
  - When `hold_cnt` reaches MAX_HOLD-1 and `req[0]` is still high, next = OWN0.
  - The preempted requester keeps `req` high and competes again after P0 releases.
- **`rr_last`:** updates to i when entering OWN1 or OWN2.
- **Port mux:**
  - `bram_en` = `acc_en[i]` of the current owner; 0 in NONE.
  - `bram_we`, `bram_addr` and `bram_din` follow the owner's inputs.
  - In NONE they are driven to 0.
  - Strobes from non-owners are dropped silently.
- **Read tag:** on an owner access with `acc_en=1` and `acc_we=0`, register `rd_pend=1` and `rd_tag=i`. The next cycle, `rvalid[rd_tag]` is 1. This holds even if ownership changed in between.
- **`rdata`:** combinationally equals `bram_dout`.

## Timing
- **Reset values:** state NONE, `gnt`=0, `rvalid`=0, `bram_en`/`bram_we`/`bram_addr`/`bram_din`=0, `owner`=0, `hold_cnt`=0, `rr_last`=P2 (so P1 wins first).
- **Grant latency:** `req` rises in cycle n, `gnt` is high in n+1 at the earliest. An access strobe is legal from n+1.
- **Release:** `req[i]` low in cycle n, `gnt[i]` low in n+1. A next owner selected at n has its `gnt` high in n+1.
- **Read latency:** `acc_en` in cycle n, `rvalid` in n+1, `rdata` valid in the same cycle as `rvalid`.
- **Back-to-back reads:** one `rvalid` per cycle, and the tag pipeline is single-depth.
- **Writes:** a write in cycle n is visible to a read issued at n+1.
- **Simultaneous requests:**
  - `req` = 3'b111 from NONE grants P0.
  - After P0 releases with P1 and P2 both waiting, the grant goes to the one not in `rr_last`.
- **Asynchronous reset mid-burst:** every output drops to its reset value immediately. Any pending `rvalid` is discarded.

## Structure
- **Shared package `copro_pkg`:**
  - `owner_t` enum (NONE, OWN0, OWN1, OWN2).
  - Requester index constants `REQ_LOAD`=0, `REQ_COMP`=1, `REQ_READBACK`=2.
  - BRAM depth constant 1024.
- **Implementation:** single module, no sub-modules. The mux is a case on state, and the tag/hold logic is plain registers.

## Test plan
- **Single grant:** reset, then `req`=3'b010. Expect `gnt`=3'b010 one cycle later. A read of addr 5 gives `rvalid`=3'b010 one cycle after the strobe, with `rdata`=BRAM[5].
- **P0 priority:** `req`=3'b111 from NONE. Expect OWN0. On P0 release, expect OWN1. On P1 release, expect OWN2.
- **Write-then-read:** P0 writes 0xA5 to addr 1023. Then P2 reads addr 1023 and gets `rvalid[2]` with `rdata`=0xA5.
- **Preemption:** P1 holds `req` with continuous reads, then `req[0]` rises. Expect OWN0 after exactly MAX_HOLD=16 cycles. A read strobed in the last OWN1 cycle still returns `rvalid[1]`.
- **Fairness:** P1 and P2 both continuously re-request, each releasing after 4 cycles. Grants alternate P1, P2, P1, P2.
- **Reset mid-burst:** assert `rst_n`=0 during an OWN2 read. Expect all outputs 0 immediately and no `rvalid` after release. The next request is granted normally.

Source files
------------

// File: rtl/copro_pkg.sv
// Shared types and constants for the coprocessor operand-memory slice.
// Holds the owner state encoding and the next-owner selection rule.
package copro_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    OWN2 = 2'd3
  } owner_t;

  localparam int REQ_LOAD     = 0;
  localparam int REQ_COMP     = 1;
  localparam int REQ_READBACK = 2;

  localparam int BRAM_DEPTH = 1024;
  localparam int BRAM_AW    = $clog2(BRAM_DEPTH);

  // P0 always wins; P1/P2 alternate when both ask (rr_p2_last=1 means P2 went last).
  function automatic owner_t pick(input logic [2:0] r, input logic rr_p2_last);
    owner_t nxt;
    nxt = NONE;
    if (r[REQ_LOAD])
      nxt = OWN0;
    else if (r[REQ_COMP] && r[REQ_READBACK])
      nxt = rr_p2_last ? OWN1 : OWN2;
    else if (r[REQ_COMP])
      nxt = OWN1;
    else if (r[REQ_READBACK])
      nxt = OWN2;
    return nxt;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the operand BRAM arbiter: requests, access strobes,
// grants and tagged read returns for the three requesters.
interface bram_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic [2:0]      req;
  logic [2:0]      acc_en;
  logic [2:0]      acc_we;
  logic [3*AW-1:0] acc_addr;
  logic [3*DW-1:0] acc_din;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output req, acc_en, acc_we, acc_addr, acc_din,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, acc_en, acc_we, acc_addr, acc_din,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM read/write port between loader (P0), compute (P1) and
// readback (P2); P0 has priority, P1/P2 round-robin, reads are tagged back.
//
// state | meaning
// NONE  | port idle, no owner
// OWN0  | UART loader owns the port
// OWN1  | compute engine owns the port
// OWN2  | UART readback owns the port
module bram_port_arbiter
  import copro_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int AW       = BRAM_AW,
  parameter int DW       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_port_arbiter_if.slave    bus,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [AW-1:0]         bram_addr,
  output logic [DW-1:0]         bram_din,
  input  logic [DW-1:0]         bram_dout,
  output logic [1:0]            owner
);

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  owner_t        state, state_nxt;
  logic          rr_p2_last;
  logic [HW-1:0] hold_cnt;
  logic          rd_pend;
  logic [1:0]    rd_tag;
  logic [1:0]    own_idx;
  logic [2:0]    gnt;

  always_comb begin
    state_nxt = state;
    case (state)
      NONE: state_nxt = pick(bus.req, rr_p2_last);
      OWN0: if (!bus.req[REQ_LOAD]) state_nxt = pick(bus.req & 3'b110, rr_p2_last);
      OWN1: begin
        if (!bus.req[REQ_COMP])
          state_nxt = pick(bus.req & 3'b101, rr_p2_last);
        else if (bus.req[REQ_LOAD] && hold_cnt == HOLD_LAST)
          state_nxt = OWN0;
      end
      OWN2: begin
        if (!bus.req[REQ_READBACK])
          state_nxt = pick(bus.req & 3'b011, rr_p2_last);
        else if (bus.req[REQ_LOAD] && hold_cnt == HOLD_LAST)
          state_nxt = OWN0;
      end
      default: state_nxt = NONE;
    endcase
  end

  always_comb begin
    gnt       = 3'b000;
    own_idx   = 2'd0;
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    case (state)
      OWN0: begin
        gnt[REQ_LOAD] = 1'b1;
        own_idx       = 2'(REQ_LOAD);
        bram_en       = bus.acc_en[REQ_LOAD];
        bram_we       = bus.acc_we[REQ_LOAD];
        bram_addr     = bus.acc_addr[REQ_LOAD*AW +: AW];
        bram_din      = bus.acc_din[REQ_LOAD*DW +: DW];
      end
      OWN1: begin
        gnt[REQ_COMP] = 1'b1;
        own_idx       = 2'(REQ_COMP);
        bram_en       = bus.acc_en[REQ_COMP];
        bram_we       = bus.acc_we[REQ_COMP];
        bram_addr     = bus.acc_addr[REQ_COMP*AW +: AW];
        bram_din      = bus.acc_din[REQ_COMP*DW +: DW];
      end
      OWN2: begin
        gnt[REQ_READBACK] = 1'b1;
        own_idx           = 2'(REQ_READBACK);
        bram_en           = bus.acc_en[REQ_READBACK];
        bram_we           = bus.acc_we[REQ_READBACK];
        bram_addr         = bus.acc_addr[REQ_READBACK*AW +: AW];
        bram_din          = bus.acc_din[REQ_READBACK*DW +: DW];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NONE;
      rr_p2_last <= 1'b1;
      hold_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_tag     <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state && state_nxt == OWN1)
        rr_p2_last <= 1'b0;
      else if (state_nxt != state && state_nxt == OWN2)
        rr_p2_last <= 1'b1;
      // Hold budget only runs while P0 is kept waiting by the current owner.
      if ((state == OWN1 || state == OWN2) && state_nxt == state && bus.req[REQ_LOAD])
        hold_cnt <= hold_cnt + 1'b1;
      else
        hold_cnt <= '0;
      rd_pend <= bram_en & ~bram_we;
      rd_tag  <= own_idx;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = rd_pend ? 3'(3'b001 << rd_tag) : 3'b000;
  assign bus.rdata  = bram_dout;
  assign owner      = state;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioural 1024x8 BRAM
// preloaded with mem[a] = a*7+1 (8-bit wrap).
module tb_bram_port_arbiter;
  import copro_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int MAX_HOLD = 16;

  typedef struct {
    logic [2:0] vld;
    logic [7:0] data;
    longint     t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, bram_dout;
  logic [1:0] owner;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  bram_port_arbiter #(.MAX_HOLD(MAX_HOLD), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 1);
      loaded = 1'b1;
    end else if (bram_en) begin
      if (bram_we) mem[bram_addr] = bram_din;
      else bram_dout <= mem[bram_addr];
    end
  end

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 1);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.acc_en   = 3'b000;
    bus.acc_we   = 3'b000;
    bus.acc_addr = '0;
    bus.acc_din  = '0;
  endtask

  task automatic rd(input int p, input int a, input logic [7:0] d);
    exp_t e;
    bus.acc_en[p] = 1'b1;
    bus.acc_we[p] = 1'b0;
    bus.acc_addr[p*AW +: AW] = AW'(a);
    e.vld  = 3'(1 << p);
    e.data = d;
    e.t    = longint'($time);
    sb.push_back(e);
  endtask

  task automatic wr(input int p, input int a, input logic [7:0] d);
    bus.acc_en[p] = 1'b1;
    bus.acc_we[p] = 1'b1;
    bus.acc_addr[p*AW +: AW] = AW'(a);
    bus.acc_din[p*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Monitor: every read return must match the oldest issued read, one cycle later.
  always @(negedge clk) begin
    if (bus.rvalid !== 3'b000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: got rvalid=%b rdata=%h expected no return at %0t",
                 bus.rvalid, bus.rdata, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.rvalid !== e.vld || bus.rdata !== e.data || longint'($time) - e.t != 10) begin
          errors++;
          $display("FAIL read_return: got rvalid=%b rdata=%h lat=%0d expected rvalid=%b rdata=%h lat=10",
                   bus.rvalid, bus.rdata, longint'($time) - e.t, e.vld, e.data);
        end
      end
    end
  end

  initial begin
    int exp_own;
    rst_n   = 1'b0;
    bus.req = 3'b000;
    idle();
    step();
    step();
    chk("reset_gnt", bus.gnt, 0);
    chk("reset_owner", owner, 0);
    chk("reset_rvalid", bus.rvalid, 0);
    chk("reset_bram_en", bram_en, 0);
    chk("reset_bram_we", bram_we, 0);
    chk("reset_bram_addr", bram_addr, 0);
    chk("reset_bram_din", bram_din, 0);
    rst_n = 1'b1;
    step();

    // P0 priority, then P1 (first round-robin pick), then P2
    bus.req = 3'b111; step();
    chk("prio_own0", owner, 1);
    chk("prio_gnt0", bus.gnt, 3'b001);
    bus.req = 3'b110; step();
    chk("prio_own1", owner, 2);
    bus.req = 3'b100; step();
    chk("prio_own2", owner, 3);
    chk("prio_gnt2", bus.gnt, 3'b100);
    bus.req = 3'b000; step();
    chk("prio_none", owner, 0);
    chk("prio_gnt_none", bus.gnt, 0);

    // single grant, non-owner strobe dropped, owner read of addr 5
    bus.req = 3'b010; step();
    chk("single_gnt", bus.gnt, 3'b010);
    bus.acc_en[2] = 1'b1;
    bus.acc_addr[2*AW +: AW] = 10'd6;
    #1 chk("nonowner_dropped", bram_en, 0);
    step();
    idle();
    rd(1, 5, 8'h24);
    #1;
    chk("mux_en", bram_en, 1);
    chk("mux_addr", bram_addr, 5);
    step();
    idle();
    bus.req = 3'b000; step();
    chk("single_release", bus.gnt, 0);

    // write 0xA5 to 1023 by P0, read back by P2
    bus.req = 3'b001; step();
    chk("wr_own0", owner, 1);
    wr(0, 1023, 8'hA5);
    #1 chk("wr_mux_we", bram_we, 1);
    step();
    idle();
    bus.req = 3'b100; step();
    chk("rd_own2", owner, 3);
    rd(2, 1023, 8'hA5);
    step();
    idle();
    bus.req = 3'b000; step();

    // preemption: P1 streams reads, P0 raised at k=2; 16 owned cycles then OWN0
    bus.req = 3'b010; step();
    chk("pre_own1", owner, 2);
    for (int k = 0; k < 18; k++) begin
      rd(1, 100 + k, pat(100 + k));
      if (k == 2) bus.req[0] = 1'b1;
      step();
      if (k < 17) chk("pre_hold", owner, 2);
    end
    chk("pre_own0", owner, 1);
    idle();
    step();
    bus.req = 3'b010; step();
    chk("pre_resume", owner, 2);
    bus.req = 3'b000; step();

    // fairness: P1/P2 each hold 4 cycles, then re-request
    do_reset();
    bus.req = 3'b110; step();
    exp_own = 2;
    for (int g = 0; g < 4; g++) begin
      chk("fair_grant", owner, 32'(exp_own));
      step(); step(); step();
      bus.req[exp_own - 1] = 1'b0;
      step();
      bus.req = 3'b110;
      exp_own = (exp_own == 2) ? 3 : 2;
    end
    bus.req = 3'b000; step(); step();

    // asynchronous reset during an OWN2 read
    bus.req = 3'b100; step();
    chk("rst_own2", owner, 3);
    bus.acc_en[2] = 1'b1;
    bus.acc_we[2] = 1'b0;
    bus.acc_addr[2*AW +: AW] = 10'd7;
    #6 rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt", bus.gnt, 0);
    chk("rst_mid_owner", owner, 0);
    chk("rst_mid_rvalid", bus.rvalid, 0);
    chk("rst_mid_bram_en", bram_en, 0);
    chk("rst_mid_bram_addr", bram_addr, 0);
    idle();
    bus.req = 3'b000;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_after_rvalid", bus.rvalid, 0);
    bus.req = 3'b100; step();
    chk("rst_regrant", owner, 3);
    rd(2, 9, 8'h40);
    step();
    idle();
    bus.req = 3'b000; step(); step();

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
